instruction_parser: RTL
=======================

// Module: instruction_parser
// PURPOSE
// - Upstream feeder of the instruction buffer: turns the ASCII byte stream of the light-grid puzzle
//   ("turn on 0,0 through 999,999\n", "turn off ...", "toggle ...") into packed instruction words.
// - Writes one word per parsed line on the buffer's write port (no backpressure).
// - Accepts one byte per clock; a single clock domain.
// PARAMETERS
// - COORD_WIDTH        10   bits per coordinate field
// - INSTRUCTION_WIDTH  (localparam) 4 + 4*COORD_WIDTH = 44
// PORTS
// - clk       in   1   sole clock
// - reset     in   1   synchronous, active-high
// - in_valid  in   1   in_data carries a byte this cycle
// - in_data   in   8   ASCII byte
// - in_last   in   1   qualifies the final byte of the stream (with in_valid)
// - wr_valid  out  1   one-cycle write strobe to the buffer
// - wr_data   out  IW  {last[IW-1], valid[IW-2], op[IW-3:IW-4], x0, y0, x1, y1} (MSB..LSB)
// - done      out  1   high from the cycle after the last-flagged word is written until reset
// BEHAVIOUR
// - Reset state and outputs:
//   - wr_valid=0, wr_data=0, done=0.
//   - Line state is cleared: letter count 0, field index 0, fields 0, op unknown, digit-seen 0.
// - Reset mid-line discards the partial line; no word is emitted.
// - Op encoding: 01 turn on, 00 turn off, 10 toggle, 11 NOP terminator.
// - Keyword decode, letters a-z only:
//   - Letters count only before the first digit of a line; later letters ("through") are ignored.
//   - Letter idx1: 'o' -> toggle, 'u' -> turn.
//   - Letter idx5 of "turn": 'n' -> on, 'f' -> off.
// - Digit handling:
//   - Each digit updates field[idx] <= field[idx]*10 + d, mod 2**COORD_WIDTH (wrap, no saturation).
//   - A digit sets digit-seen.
// - Field separators:
//   - Any non-digit, non-newline byte with digit-seen=1 advances idx (max 3) and clears digit-seen.
//   - Field order is x0, y0, x1, y1.
// - '\r', and bytes with in_valid=0, are ignored.
// - Line end is '\n', or any byte with in_last=1 (processed first, then treated as line end).
// - A line is complete when:
//   - idx=3 with digit-seen=1, or idx advanced past the 4th field, and
//   - the op is known.
// - Line end with a complete line:
//   - Next cycle: wr_valid=1, valid=1, op, fields, last=in_last.
//   - Line state is then cleared.
// - Line end with a blank or malformed line: nothing is emitted and the line state is cleared.
// - Exception: if in_last=1, emit a terminator word {last=1, valid=1, op=11, coords 0}, so
//   downstream always sees last.
// - Latency: line-ending byte at cycle N -> wr_valid at N+1, for exactly one cycle.
// - Back-to-back lines are allowed (consecutive "\n" bytes spaced by 1 cycle).
// - After done=1, further in_valid bytes are ignored until reset.
// - wr_data holds its last value while wr_valid=0.
// CONFIGURATION
// - PARSER_STATS_EN defined:
//   - Adds outputs stat_instr[15:0] (count of op!=11 words written) and stat_drop[15:0]
//     (non-blank malformed lines).
//   - Both are 0 at reset and saturate at 16'hFFFF.
// - PARSER_STATS_EN undefined: no counters and no extra ports; everything else is identical.
// TESTING
// - "turn on 0,0 through 999,999\n" -> one strobe, wr_data = {0,1,01,0,0,999,999}.
// - "toggle 499,499 through 500,500\n" then "turn off 1,2 through 3,4\n" with in_last on the
//   final '\n' -> two strobes, op 10 then 00, the second with last=1; done=1 next cycle.
// - "\n\nturn on 5,5 through 5,5" with in_last on the final '5' (no newline)
//   -> one word {1,1,01,5,5,5,5}.
// - "turn on 1,2\n" then a blank line with in_last -> malformed line dropped;
//   terminator {1,1,11,0,0,0,0}; stat_drop=1 with PARSER_STATS_EN.
// - "toggle 1024,3 through 0,0\n" -> x0 wraps to 0.
//   Reset asserted mid-"turn of" -> no strobe; the next full line parses correctly.
// - in_valid gaps between every byte of a line -> same word as the gap-free stream.

Source files
------------

// File: rtl/instruction_parser_if.sv
// Byte-stream input and instruction-buffer write port of instruction_parser.
// master = byte source / buffer side, slave = the parser.
interface instruction_parser_if #(
  parameter int COORD_WIDTH = 10
);
  localparam int IW = 4 + 4 * COORD_WIDTH;

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_last;
  logic          wr_valid;
  logic [IW-1:0] wr_data;
  logic          done;

  modport master (
    output in_valid, in_data, in_last,
    input  wr_valid, wr_data, done
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output wr_valid, wr_data, done
  );
endinterface

// File: rtl/instruction_parser.sv
// Parses ASCII light-grid instructions into packed words {last, valid, op, x0, y0, x1, y1}.
// Optional PARSER_STATS_EN adds saturating stat_instr / stat_drop counters.
module instruction_parser #(
  parameter int COORD_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  instruction_parser_if.slave  bus
`ifdef PARSER_STATS_EN
  ,
  output logic [15:0]          stat_instr,
  output logic [15:0]          stat_drop
`endif
);
  localparam int CW = COORD_WIDTH;
  localparam int IW = 4 + 4 * CW;

  typedef enum logic [1:0] {
    OP_OFF    = 2'b00,
    OP_ON     = 2'b01,
    OP_TOGGLE = 2'b10,
    OP_NOP    = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_PARSE,
    S_LAST,
    S_DONE
  } state_t;

  state_t state, state_nxt;

  // Line state
  logic [2:0]    lcnt,         lcnt_nxt;
  logic          num_started,  num_started_nxt;
  logic          digit_seen,   digit_seen_nxt;
  logic [1:0]    idx,          idx_nxt;
  logic          past,         past_nxt;
  logic [CW-1:0] field [4];
  logic [CW-1:0] field_nxt [4];
  op_t           op,           op_nxt;
  logic          op_known,     op_known_nxt;
  logic          is_turn,      is_turn_nxt;
  logic          nonblank,     nonblank_nxt;

  logic          wr_valid_q;
  logic [IW-1:0] wr_data_q;

  logic          accept, is_digit, is_letter, is_nl, is_cr, is_space;
  logic          line_end, complete, emit_word, emit_term;
  logic [CW-1:0] cur, acc;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= S_PARSE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_PARSE: if (line_end && bus.in_last) state_nxt = S_LAST;
      S_LAST:  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_DONE;
      default: state_nxt = S_PARSE;
    endcase
  end

  always_comb begin
    bus.done     = (state == S_DONE);
    bus.wr_valid = wr_valid_q;
    bus.wr_data  = wr_data_q;
  end

  // ---------------------------------------------------------- byte decode
  always_comb begin
    accept    = bus.in_valid && (state == S_PARSE);
    is_digit  = (bus.in_data >= 8'h30) && (bus.in_data <= 8'h39);
    is_letter = (bus.in_data >= 8'h61) && (bus.in_data <= 8'h7A);
    is_nl     = (bus.in_data == 8'h0A);
    is_cr     = (bus.in_data == 8'h0D);
    is_space  = (bus.in_data == 8'h20) || (bus.in_data == 8'h09);
    cur       = field[idx];
    acc       = (cur << 3) + (cur << 1) + CW'(bus.in_data[3:0]);
  end

  // Next line state after applying this byte; the line-end decision uses
  // these values so a final in_last digit is folded in before completion.
  always_comb begin
    lcnt_nxt        = lcnt;
    num_started_nxt = num_started;
    digit_seen_nxt  = digit_seen;
    idx_nxt         = idx;
    past_nxt        = past;
    field_nxt       = field;
    op_nxt          = op;
    op_known_nxt    = op_known;
    is_turn_nxt     = is_turn;
    nonblank_nxt    = nonblank;

    if (accept && !is_nl && !is_cr) begin
      if (is_digit) begin
        num_started_nxt = 1'b1;
        nonblank_nxt    = 1'b1;
        digit_seen_nxt  = 1'b1;
        if (!past) field_nxt[idx] = acc;
      end else begin
        if (!is_space) nonblank_nxt = 1'b1;
        if (digit_seen) begin
          digit_seen_nxt = 1'b0;
          if (idx == 2'd3) past_nxt = 1'b1;
          else             idx_nxt  = idx + 2'd1;
        end
        if (is_letter && !num_started) begin
          if (lcnt != 3'd7) lcnt_nxt = lcnt + 3'd1;
          if (lcnt == 3'd1) begin
            if (bus.in_data == "o") begin
              op_nxt       = OP_TOGGLE;
              op_known_nxt = 1'b1;
            end else if (bus.in_data == "u") begin
              is_turn_nxt = 1'b1;
            end
          end
          if (lcnt == 3'd5 && is_turn) begin
            if (bus.in_data == "n") begin
              op_nxt       = OP_ON;
              op_known_nxt = 1'b1;
            end else if (bus.in_data == "f") begin
              op_nxt       = OP_OFF;
              op_known_nxt = 1'b1;
            end
          end
        end
      end
    end

    line_end  = accept && (is_nl || bus.in_last);
    complete  = op_known_nxt && ((idx_nxt == 2'd3 && digit_seen_nxt) || past_nxt);
    emit_word = line_end && complete;
    emit_term = line_end && !complete && bus.in_last;
  end

  // ------------------------------------------------------------ line state
  always_ff @(posedge clk) begin
    if (reset || line_end) begin
      lcnt        <= '0;
      num_started <= 1'b0;
      digit_seen  <= 1'b0;
      idx         <= '0;
      past        <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) field[i] <= '0;
      op          <= OP_NOP;
      op_known    <= 1'b0;
      is_turn     <= 1'b0;
      nonblank    <= 1'b0;
    end else if (accept) begin
      lcnt        <= lcnt_nxt;
      num_started <= num_started_nxt;
      digit_seen  <= digit_seen_nxt;
      idx         <= idx_nxt;
      past        <= past_nxt;
      for (int unsigned i = 0; i < 4; i++) field[i] <= field_nxt[i];
      op          <= op_nxt;
      op_known    <= op_known_nxt;
      is_turn     <= is_turn_nxt;
      nonblank    <= nonblank_nxt;
    end
  end

  // ---------------------------------------------------------- write port
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= emit_word || emit_term;
      if (emit_word)
        wr_data_q <= {bus.in_last, 1'b1, op_nxt,
                      field_nxt[0], field_nxt[1], field_nxt[2], field_nxt[3]};
      else if (emit_term)
        wr_data_q <= {2'b11, OP_NOP, {(4 * CW){1'b0}}};
    end
  end

`ifdef PARSER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_instr <= '0;
      stat_drop  <= '0;
    end else begin
      if (emit_word && stat_instr != '1)
        stat_instr <= stat_instr + 16'd1;
      if (line_end && !complete && nonblank_nxt && stat_drop != '1)
        stat_drop <= stat_drop + 16'd1;
    end
  end
`endif

endmodule
